mux_arbiter: RTL and testbench



---
 rtl/mux_arbiter_pkg.sv | 20 ++
 rtl/mux_arbiter_mux.sv | 20 ++
 rtl/mux_arbiter.sv | 117 +++++++++++
 tb/tb_mux_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mux_arbiter_pkg : state encoding, source codes and defaults for mux_arbiter
// Revision        : 1.0
// ----------------------------------------------------------------------------
package mux_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam logic SRC_A = 1'b1;
  localparam logic SRC_B = 1'b0;

  localparam int MAX_BURST_DEF = 4;

endpackage
`default_nettype wire

// File: rtl/mux_arbiter_mux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mux_arbiter_mux : shared 2:1 datapath mux, select high picks input A
// Revision        : 1.0
// ----------------------------------------------------------------------------
module mux_arbiter_mux
  import mux_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = (i_sel == SRC_A) ? i_a : i_b;

endmodule
`default_nettype wire

// File: rtl/mux_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mux_arbiter : round-robin burst arbiter for two producers sharing one mux,
//               with a single-entry valid/ready output register
// Revision    : 1.0
// ----------------------------------------------------------------------------
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             ack_b,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);

  state_t           r_state;
  logic             r_last;
  logic [7:0]       r_beat_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_src;

  logic             w_own_a;
  logic             w_own_b;
  logic             w_req_own;
  logic             w_req_oth;
  logic             w_slot_free;
  logic             w_accept;
  logic             w_burst_done;
  logic [8:0]       w_beat_next;
  logic [WIDTH-1:0] w_mux_y;

  assign w_own_a      = (r_state == OWN_A);
  assign w_own_b      = (r_state == OWN_B);
  assign w_req_own    = w_own_a ? req_a : req_b;
  assign w_req_oth    = w_own_a ? req_b : req_a;
  assign w_slot_free  = !r_out_valid || out_ready;
  assign w_accept     = (w_own_a || w_own_b) && w_req_own && w_slot_free;
  assign w_beat_next  = {1'b0, r_beat_cnt} + 9'd1;
  // >= so that a count saturated during a solo run still yields once the peer asks
  assign w_burst_done = (w_beat_next >= 9'(MAX_BURST));

  assign ack_a     = w_own_a && req_a && w_slot_free;
  assign ack_b     = w_own_b && req_b && w_slot_free;
  assign sel       = w_own_a;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

  mux_arbiter_mux #(
    .WIDTH (WIDTH)
  ) u_mux (
    .i_a   (data_a),
    .i_b   (data_b),
    .i_sel (sel),
    .o_y   (w_mux_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last      <= SRC_B;
      r_beat_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= SRC_B;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_mux_y;
        r_out_src   <= w_own_a ? SRC_A : SRC_B;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (req_a && (!req_b || r_last == SRC_B)) begin
            r_state    <= OWN_A;
            r_last     <= SRC_A;
            r_beat_cnt <= '0;
          end else if (req_b) begin
            r_state    <= OWN_B;
            r_last     <= SRC_B;
            r_beat_cnt <= '0;
          end
        end
        OWN_A, OWN_B: begin
          if ((!w_req_own || (w_accept && w_burst_done)) && w_req_oth) begin
            r_state    <= w_own_a ? OWN_B : OWN_A;
            r_last     <= w_own_a ? SRC_B : SRC_A;
            r_beat_cnt <= '0;
          end else if (!w_req_own) begin
            r_state <= IDLE;
          end else if (w_accept) begin
            r_beat_cnt <= w_burst_done ? 8'(MAX_BURST) : w_beat_next[7:0];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mux_arbiter : directed scenarios plus randomized traffic against a model
// Revision       : 1.0
// ----------------------------------------------------------------------------
module tb_mux_arbiter;

  localparam int WIDTH = 32;
  localparam int MAXB  = 4;

  logic             clk;
  logic             rst_n;
  logic             req_a;
  logic             req_b;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             ack_a;
  logic             ack_b;
  logic             sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;

  int errors = 0;
  int checks = 0;

  // model: owner 0 = none, 1 = A, 2 = B; beats counts the current tenure
  int          m_own;
  int          m_last;
  int          m_beats;
  bit          m_ov;
  logic [31:0] m_od;
  bit          m_os;

  mux_arbiter #(
    .WIDTH     (WIDTH),
    .MAX_BURST (MAXB)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .data_a    (data_a),
    .ack_a     (ack_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .ack_b     (ack_b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0;
    data_a = '0; data_b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic model_reset();
    m_own = 0; m_last = 2; m_beats = 0; m_ov = 0; m_od = '0; m_os = 0;
  endtask

  task automatic model_grant(input int id);
    m_own = id; m_beats = 0; m_last = id;
  endtask

  task automatic model_edge();
    bit free, take, mine, other;
    free  = !m_ov || out_ready;
    mine  = (m_own == 1) ? req_a : req_b;
    other = (m_own == 1) ? req_b : req_a;
    take  = (m_own != 0) && mine && free;
    if (take) begin
      m_ov = 1; m_od = (m_own == 1) ? data_a : data_b; m_os = (m_own == 1);
    end else if (out_ready) begin
      m_ov = 0;
    end
    if (m_own == 0) begin
      if (req_a && req_b) model_grant(m_last == 1 ? 2 : 1);
      else if (req_a)     model_grant(1);
      else if (req_b)     model_grant(2);
    end else if (!mine) begin
      if (other) model_grant(3 - m_own);
      else       m_own = 0;
    end else if (take) begin
      m_beats++;
      if (m_beats >= MAXB && other) model_grant(3 - m_own);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_a = 1'b1; req_b = 1'b0;
    data_a = 32'hAAAAAAAA; data_b = '0; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({ack_a, ack_b, sel, out_valid, out_src, out_data} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got ack_a=%b ack_b=%b sel=%b ov=%b src=%b data=%h want all 0",
                 ack_a, ack_b, sel, out_valid, out_src, out_data);
      end
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ack_a !== 1'b0 || sel !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_cycle: got ack_a=%b sel=%b want 0 0", ack_a, sel);
    end
    @(negedge clk);
    checks++;
    if (ack_a !== 1'b1 || sel !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant: got ack_a=%b sel=%b want 1 1", ack_a, sel);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hAAAAAAAA || out_src !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_word: got ov=%b data=%h src=%b want 1 aaaaaaaa 1",
               out_valid, out_data, out_src);
    end
  endtask

  task automatic test_tie_fairness();
    logic [1:0]  want_seq [10];
    logic [31:0] a_words  [4];
    logic [31:0] want_word;
    logic        want_src;
    bit          prev_ack;
    int          ai;
    want_seq = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    a_words  = '{32'h0, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h3C3C3C3C};
    ai = 0; prev_ack = 0; want_word = '0; want_src = 0;
    do_reset();
    req_a = 1'b1; req_b = 1'b1; data_a = a_words[0]; data_b = 32'hB0000000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({ack_a, ack_b} !== want_seq[c]) begin
        errors++;
        $display("FAIL tie_order cycle %0d: got {ack_a,ack_b}=%b want %b", c, {ack_a, ack_b}, want_seq[c]);
      end
      if (prev_ack) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== want_word || out_src !== want_src) begin
          errors++;
          $display("FAIL tie_data cycle %0d: got ov=%b data=%h src=%b want 1 %h %b",
                   c, out_valid, out_data, out_src, want_word, want_src);
        end
      end
      prev_ack  = ack_a || ack_b;
      want_word = ack_a ? data_a : data_b;
      want_src  = ack_a;
      @(posedge clk); #1;
      if (prev_ack && want_src) begin
        ai++;
        data_a = (ai < 4) ? a_words[ai] : 32'h12340000 + ai;
      end else if (prev_ack) begin
        data_b = data_b + 1;
      end
    end
  endtask

  task automatic test_backpressure();
    int nack;
    nack = 0;
    do_reset();
    req_b = 1'b1; data_b = 32'h55555555; out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      nack += int'(ack_b);
      if (c >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h55555555 || sel !== 1'b0 || ack_a !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold cycle %0d: got ov=%b data=%h sel=%b ack_a=%b want 1 55555555 0 0",
                   c, out_valid, out_data, sel, ack_a);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (nack != 1) begin
      errors++;
      $display("FAIL stall_ack_count: got %0d want 1", nack);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ack_b !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ack: got ack_b=%b want 1", ack_b);
    end
  endtask

  task automatic test_owner_drop();
    logic [1:0] want_tail [4];
    want_tail = '{2'b01, 2'b01, 2'b01, 2'b10};
    do_reset();
    req_a = 1'b1; req_b = 1'b1; data_a = 32'h11111111; data_b = 32'hDDDDDDDD;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (ack_a !== (c != 0) || ack_b !== 1'b0) begin
        errors++;
        $display("FAIL drop_pre cycle %0d: got ack_a=%b ack_b=%b want %b 0", c, ack_a, ack_b, c != 0);
      end
      @(posedge clk); #1;
    end
    req_a = 1'b0;
    @(negedge clk);
    checks++;
    if (ack_a !== 1'b0 || ack_b !== 1'b0 || sel !== 1'b1) begin
      errors++;
      $display("FAIL drop_gap: got ack_a=%b ack_b=%b sel=%b want 0 0 1", ack_a, ack_b, sel);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (sel !== 1'b0 || ack_b !== 1'b1) begin
      errors++;
      $display("FAIL drop_handover: got sel=%b ack_b=%b want 0 1", sel, ack_b);
    end
    @(posedge clk); #1 req_a = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hDDDDDDDD || out_src !== 1'b0) begin
          errors++;
          $display("FAIL drop_first_b: got ov=%b data=%h src=%b want 1 dddddddd 0",
                   out_valid, out_data, out_src);
        end
      end
      checks++;
      if ({ack_a, ack_b} !== want_tail[c]) begin
        errors++;
        $display("FAIL drop_new_burst step %0d: got %b want %b", c, {ack_a, ack_b}, want_tail[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_solo_overrun();
    int nack;
    nack = 0;
    do_reset();
    req_b = 1'b1; data_b = 32'hFFFFFFFF;
    @(negedge clk);
    @(posedge clk); #1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      nack += int'(ack_b);
      checks++;
      if (ack_b !== 1'b1 || ack_a !== 1'b0 || sel !== 1'b0) begin
        errors++;
        $display("FAIL solo_beat %0d: got ack_b=%b ack_a=%b sel=%b want 1 0 0", c, ack_b, ack_a, sel);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (nack != 10 || ack_b !== 1'b1 || out_data !== 32'hFFFFFFFF || out_src !== 1'b0) begin
      errors++;
      $display("FAIL solo_summary: got acks=%0d ack_b=%b data=%h src=%b want 10 1 ffffffff 0",
               nack, ack_b, out_data, out_src);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req_a = 1'b1; req_b = 1'b1; data_a = 32'h12345678; data_b = 32'h87654321;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || ack_a !== 1'b1 || sel !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: got ov=%b ack_a=%b sel=%b want 1 1 1", out_valid, ack_a, sel);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || ack_a !== 1'b0 || sel !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL areset_drop: got ov=%b ack_a=%b sel=%b data=%h want 0 0 0 0",
               out_valid, ack_a, sel, out_data);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (ack_a !== 1'b1 || ack_b !== 1'b0) begin
      errors++;
      $display("FAIL areset_tie: got ack_a=%b ack_b=%b want 1 0", ack_a, ack_b);
    end
  endtask

  task automatic test_random();
    bit ea, eb;
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      ea = (m_own == 1) && req_a && (!m_ov || out_ready);
      eb = (m_own == 2) && req_b && (!m_ov || out_ready);
      checks++;
      if (ack_a !== ea || ack_b !== eb || sel !== (m_own == 1) || out_valid !== m_ov) begin
        errors++;
        $display("FAIL rand_ctrl cycle %0d: got ack=%b%b sel=%b ov=%b want %b%b %b %b",
                 c, ack_a, ack_b, sel, out_valid, ea, eb, m_own == 1, m_ov);
      end
      if (m_ov) begin
        checks++;
        if (out_data !== m_od || out_src !== m_os) begin
          errors++;
          $display("FAIL rand_data cycle %0d: got %h/%b want %h/%b", c, out_data, out_src, m_od, m_os);
        end
      end
      model_edge();
      @(posedge clk); #1;
      if (ea || !req_a) begin
        req_a = ($urandom % 3) != 0; data_a = $urandom;
      end else if ($urandom % 16 == 0) begin
        req_a = 1'b0;
      end
      if (eb || !req_b) begin
        req_b = ($urandom % 3) != 0; data_b = $urandom;
      end else if ($urandom % 16 == 0) begin
        req_b = 1'b0;
      end
      out_ready = ($urandom % 4) != 0;
    end
  endtask

  initial begin
    test_reset();
    test_tie_fairness();
    test_backpressure();
    test_owner_drop();
    test_solo_overrun();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
